// File: rtl/mbist_march_engine.sv
// mbist_march_engine
//   March-test MBIST engine sitting between the CPU memory port and a
//   single-port synchronous-read RAM. In test mode it runs MATS+ or March C-
//   with a solid or checkerboard background. It logs the first failing
//   address, the first failing syndrome and a saturating fail count. In
//   functional mode the CPU drives the RAM through a zero-latency mux.
//
// Parameters: addr_w (address width, N = 2**addr_w words), data_w (word
//   width, even), cnt_w (fail counter width).
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   test_mode                1 = engine owns the memory port, 0 = CPU bypass
//   start, alg_sel, bg_sel   run request; alg 0=MATS+ 1=March C-;
//                            bg 0=solid 1=checkerboard
//   done, fail, fail_addr, fail_bits, fail_cnt   result registers
//   cpu_rd, cpu_wr, cpu_addr, cpu_din            CPU-side memory port
//   read, write, address, din                    RAM-side strobes/addr/data
//   mem_dout, dout           RAM read data (valid one cycle after read),
//                            passed straight to the CPU
//   fsm_state                engine state (IDLE=0 RUN=1 DRAIN=2 DONE=3)
// Handshake: start is a level sampled on each rising edge while the engine
//   is in IDLE or DONE with test_mode=1; it is ignored in RUN and DRAIN.
//   done stays high until the next accepted start or reset.
module mbist_march_engine #(
    parameter int addr_w = 3,
    parameter int data_w = 8,
    parameter int cnt_w  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_mode,
    input  logic              start,
    input  logic              alg_sel,
    input  logic              bg_sel,
    output logic              done,
    output logic              fail,
    output logic [addr_w-1:0] fail_addr,
    output logic [data_w-1:0] fail_bits,
    output logic [cnt_w-1:0]  fail_cnt,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [addr_w-1:0] cpu_addr,
    input  logic [data_w-1:0] cpu_din,
    output logic              read,
    output logic              write,
    output logic [addr_w-1:0] address,
    output logic [data_w-1:0] din,
    input  logic [data_w-1:0] mem_dout,
    output logic [data_w-1:0] dout,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    // Op encoding: {is_write, value}; value 0 -> P0 background, 1 -> P1.
    localparam logic [1:0] R0 = 2'b00, R1 = 2'b01, W0 = 2'b10, W1 = 2'b11;

    typedef struct packed {
        logic       last;  // final element of the algorithm
        logic       down;  // address order N-1 -> 0
        logic       two;   // element has two ops per address
        logic [1:0] op0;
        logic [1:0] op1;
    } elem_t;

    localparam logic [addr_w-1:0] addr_one = {{(addr_w-1){1'b0}}, 1'b1};
    localparam logic [cnt_w-1:0]  cnt_one  = {{(cnt_w-1){1'b0}}, 1'b1};

    function automatic elem_t elem_desc(input logic alg, input logic [2:0] idx);
        elem_t e;
        e = '{last: 1'b1, down: 1'b0, two: 1'b0, op0: R0, op1: R0};
        if (!alg) begin
            case (idx)
                3'd0:    e = '{last: 1'b0, down: 1'b0, two: 1'b0, op0: W0, op1: W0};
                3'd1:    e = '{last: 1'b0, down: 1'b0, two: 1'b1, op0: R0, op1: W1};
                default: e = '{last: 1'b1, down: 1'b1, two: 1'b1, op0: R1, op1: W0};
            endcase
        end else begin
            case (idx)
                3'd0:    e = '{last: 1'b0, down: 1'b0, two: 1'b0, op0: W0, op1: W0};
                3'd1:    e = '{last: 1'b0, down: 1'b0, two: 1'b1, op0: R0, op1: W1};
                3'd2:    e = '{last: 1'b0, down: 1'b0, two: 1'b1, op0: R1, op1: W0};
                3'd3:    e = '{last: 1'b0, down: 1'b1, two: 1'b1, op0: R0, op1: W1};
                3'd4:    e = '{last: 1'b0, down: 1'b1, two: 1'b1, op0: R1, op1: W0};
                default: e = '{last: 1'b1, down: 1'b0, two: 1'b0, op0: R0, op1: R0};
            endcase
        end
        return e;
    endfunction

    // P0 is 0 for solid; checkerboard alternates 01.. / 10.. by address parity.
    function automatic logic [data_w-1:0] bg_pat(input logic bg, input logic [addr_w-1:0] a,
                                                  input logic val);
        logic [data_w-1:0] p0;
        p0 = '0;
        if (bg) p0 = a[0] ? {(data_w/2){2'b10}} : {(data_w/2){2'b01}};
        return val ? ~p0 : p0;
    endfunction

    state_t            state, state_nxt;
    logic              alg_q, bg_q;
    logic [2:0]        elem_q;
    logic              op_q;
    logic [addr_w-1:0] addr_q;
    elem_t             cur;
    logic [1:0]        cur_op;
    logic              op_last, addr_end, run_last, nxt_down, start_run;
    logic              rd_pend;
    logic [addr_w-1:0] rd_addr;
    logic [data_w-1:0] rd_exp;
    logic [data_w-1:0] syndrome;
    logic              miscompare;
    logic              bist_rd, bist_wr;

    always_comb begin
        cur      = elem_desc(alg_q, elem_q);
        cur_op   = op_q ? cur.op1 : cur.op0;
        op_last  = !cur.two || op_q;
        addr_end = cur.down ? (addr_q == '0) : (addr_q == '1);
        run_last = op_last && addr_end && cur.last;
        // Direction of the element that follows elem_q, so the address
        // counter can be loaded with its start value without an idle cycle.
        nxt_down = alg_q ? (elem_q == 3'd2 || elem_q == 3'd3) : (elem_q == 3'd1);
    end

    assign start_run = (state == IDLE || state == DONE) && test_mode && start;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_run) state_nxt = RUN;
            RUN:     if (!test_mode) state_nxt = IDLE;
                     else if (run_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = test_mode ? DONE : IDLE;
            DONE:    if (start_run) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Sequencer: element index, op-within-address index, address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            alg_q  <= 1'b0;
            bg_q   <= 1'b0;
            elem_q <= '0;
            op_q   <= 1'b0;
            addr_q <= '0;
        end else if (start_run) begin
            alg_q  <= alg_sel;
            bg_q   <= bg_sel;
            elem_q <= '0;
            op_q   <= 1'b0;
            addr_q <= '0;
        end else if (state == RUN && test_mode) begin
            if (!op_last) begin
                op_q <= 1'b1;
            end else begin
                op_q <= 1'b0;
                if (addr_end) begin
                    elem_q <= elem_q + 3'd1;
                    addr_q <= nxt_down ? '1 : '0;
                end else begin
                    addr_q <= cur.down ? addr_q - addr_one : addr_q + addr_one;
                end
            end
        end
    end

    assign bist_rd = (state == RUN) && !cur_op[1];
    assign bist_wr = (state == RUN) && cur_op[1];

    // One-stage compare pipeline: read address and expected word follow the
    // read into the cycle in which mem_dout is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_addr <= '0;
            rd_exp  <= '0;
        end else begin
            rd_pend <= bist_rd && test_mode;
            rd_addr <= addr_q;
            rd_exp  <= bg_pat(bg_q, addr_q, cur_op[0]);
        end
    end

    assign syndrome   = mem_dout ^ rd_exp;
    assign miscompare = rd_pend && test_mode && (state == RUN || state == DRAIN) && (|syndrome);

    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_bits <= '0;
            fail_cnt  <= '0;
        end else if (miscompare) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + cnt_one;
            if (!fail) begin
                fail      <= 1'b1;
                fail_addr <= rd_addr;
                fail_bits <= syndrome;
            end
        end
    end

    always_comb begin
        read    = cpu_rd;
        write   = cpu_wr;
        address = cpu_addr;
        din     = cpu_din;
        if (test_mode) begin
            read    = bist_rd;
            write   = bist_wr;
            address = addr_q;
            din     = bg_pat(bg_q, addr_q, cur_op[0]);
        end
    end

    assign dout      = mem_dout;
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_mbist_march_engine.sv
module tb_mbist_march_engine;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst, test_mode, start, alg_sel, bg_sel;
  logic          done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_bits;
  logic [CW-1:0] fail_cnt;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          read, write;
  logic [AW-1:0] address;
  logic [DW-1:0] din, mem_dout, dout;
  logic [1:0]    fsm_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mbist_march_engine #(.addr_w(AW), .data_w(DW), .cnt_w(CW)) dut (
    .clk(clk), .rst(rst), .test_mode(test_mode), .start(start),
    .alg_sel(alg_sel), .bg_sel(bg_sel), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_bits(fail_bits), .fail_cnt(fail_cnt),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .read(read), .write(write), .address(address), .din(din),
    .mem_dout(mem_dout), .dout(dout), .fsm_state(fsm_state)
  );

  // ---------------- memory model with fault injection ----------------
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rdata;
  logic          stuck_en;
  logic [AW-1:0] stuck_addr;
  logic [2:0]    stuck_bit;
  logic          stuck_val;
  logic [DW-1:0] xor_all;

  function automatic logic [DW-1:0] fault_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (stuck_en && a == stuck_addr) r[stuck_bit] = stuck_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (write) mem[address] <= fault_wr(address, din);
    if (read)  rdata <= mem[address] ^ xor_all;
  end
  assign mem_dout = rdata;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at the next edge (E0); returns just after E0.
  task automatic kick(input logic alg, input logic bg);
    alg_sel = alg;
    bg_sel  = bg;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic run_test(input logic alg, input logic bg, input int exp_edge,
                          input logic e_fail, input logic [AW-1:0] e_addr,
                          input logic [DW-1:0] e_bits, input logic [CW-1:0] e_cnt,
                          input logic mid_start);
    int done_at;
    logic [15:0] res;
    exp_q.push_back({e_fail, e_addr, e_bits, e_cnt});
    kick(alg, bg);
    done_at = 0;
    for (int k = 1; k <= 300; k++) begin
      start = mid_start && (k == 20);
      tick();
      if (done) begin
        done_at = k;
        break;
      end
    end
    start = 1'b0;
    check("done_edge", done_at, exp_edge);
    res = exp_q.pop_front();
    check("result", {fail, fail_addr, fail_bits, fail_cnt}, res);
  endtask

  task automatic set_fault(input logic en, input logic [AW-1:0] a, input logic [2:0] b,
                           input logic v, input logic [DW-1:0] x);
    stuck_en   = en;
    stuck_addr = a;
    stuck_bit  = b;
    stuck_val  = v;
    xor_all    = x;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] ra;
    logic [2:0]    rb;
    logic          rv, ralg, rbg, p0bit;
    logic [CW-1:0] rcnt;

    rst = 1'b1; test_mode = 1'b0; start = 1'b0; alg_sel = 1'b0; bg_sel = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
    rdata = '0;
    set_fault(1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(1, 255));
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_faddr", fail_addr, 0);
    check("rst_fbits", fail_bits, 0);
    check("rst_fcnt", fail_cnt, 0);
    check("rst_state", fsm_state, 0);

    // CPU bypass: write then read back through the mux.
    cpu_wr = 1'b1; cpu_addr = 3'd5; cpu_din = 8'hA5;
    #1;
    check("byp_wr", {write, address, din}, {1'b1, 3'd5, 8'hA5});
    tick();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    check("byp_dout", dout, 8'hA5);

    // start ignored while test_mode=0
    start = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    start = 1'b0;
    check("byp_no_done", done, 0);
    check("byp_state", fsm_state, 0);
    check("byp_strobes", {read, write}, 0);

    test_mode = 1'b1;
    #1;
    check("idle_strobes", {read, write}, 0);

    // Clean March C-, solid background
    run_test(1'b1, 1'b0, 81, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < N; i++) check("mem_cm", mem[i], 8'h00);
    check("done_strobes", {read, write}, 0);

    // Clean MATS+, checkerboard; start mid-run must be ignored
    run_test(1'b0, 1'b1, 41, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < N; i++) check("mem_mats", mem[i], (i % 2) ? 8'hAA : 8'h55);

    // Stuck-at-0 on mem[4] bit 2
    set_fault(1'b1, 3'd4, 3'd2, 1'b0, '0);
    run_test(1'b1, 1'b0, 81, 1'b1, 3'd4, 8'h04, 4'd2, 1'b0);
    run_test(1'b1, 1'b1, 81, 1'b1, 3'd4, 8'h04, 4'd3, 1'b0);
    run_test(1'b0, 1'b0, 41, 1'b1, 3'd4, 8'h04, 4'd1, 1'b0);

    // Random single stuck-at faults
    for (int n = 0; n < 6; n++) begin
      ra   = AW'($urandom_range(0, N - 1));
      rb   = 3'($urandom_range(0, 7));
      rv   = 1'($urandom_range(0, 1));
      ralg = 1'($urandom_range(0, 1));
      rbg  = 1'($urandom_range(0, 1));
      set_fault(1'b1, ra, rb, rv, '0);
      p0bit = rbg && (ra[0] == rb[0]);
      if (!ralg)          rcnt = 4'd1;
      else if (rv != p0bit) rcnt = 4'd3;
      else                rcnt = 4'd2;
      run_test(ralg, rbg, ralg ? 81 : 41, 1'b1, ra, DW'(1) << rb, rcnt, 1'b0);
    end

    // Every read corrupted: counter saturates
    set_fault(1'b0, '0, '0, 1'b0, 8'h81);
    run_test(1'b1, 1'b0, 81, 1'b1, 3'd0, 8'h81, 4'd15, 1'b0);
    run_test(1'b0, 1'b1, 41, 1'b1, 3'd0, 8'h81, 4'd15, 1'b0);

    // Clean run after a failing one: results cleared on start
    set_fault(1'b0, '0, '0, 1'b0, '0);
    run_test(1'b0, 1'b0, 41, 1'b0, '0, '0, '0, 1'b0);

    // Reset at E30 of a failing March C- run
    set_fault(1'b1, 3'd4, 3'd2, 1'b0, '0);
    kick(1'b1, 1'b1);
    for (int k = 1; k <= 29; k++) tick();
    check("pre_rst_fail", fail, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_outs", {done, fail, fail_addr, fail_bits, fail_cnt}, 0);
    check("mid_rst_state", fsm_state, 0);
    check("mid_rst_strobes", {read, write}, 0);
    run_test(1'b1, 1'b1, 81, 1'b1, 3'd4, 8'h04, 4'd3, 1'b0);

    // test_mode dropped during RUN: abort, partial results kept
    kick(1'b1, 1'b1);
    for (int k = 1; k <= 29; k++) tick();
    test_mode = 1'b0;
    tick();
    check("abort_state", fsm_state, 0);
    check("abort_done", done, 0);
    check("abort_res", {fail, fail_addr, fail_bits, fail_cnt}, {1'b1, 3'd4, 8'h04, 4'd1});
    for (int k = 0; k < 5; k++) tick();
    check("abort_done_late", done, 0);
    test_mode = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
